// File: rtl/vec_dot_product_pipe.sv
// Pipelined vector dot product with streaming accumulation.
// Each accepted beat carries N element pairs. The beat is registered in S0.
// The N products are registered in S1. A pairwise adder tree with $clog2(N)
// registered levels reduces them. The tree sum then feeds an accumulator
// that spans beats from in_first to in_last.
// The whole pipeline advances as one unit. It freezes only while a finished
// result is waiting to be consumed, so one beat per cycle is accepted
// otherwise.
module vec_dot_product_pipe #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int ACC_W = 2*W + $clog2(N) + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   vec_a,
    input  logic [N*W-1:0]   vec_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_dot,
    output logic             out_overflow
);

    localparam int LV = $clog2(N);   // number of adder levels
    localparam int PW = 2*W;         // product width (tree level 0)
    localparam int SW = PW + LV;     // final tree sum width

    // Bit offset of tree level k inside the flat tree vectors. Level k holds
    // N>>k entries that are each PW+k bits wide.
    function automatic int lvl_off(input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) begin
            off += (N >> i) * (PW + i);
        end
        return off;
    endfunction

    localparam int TREE_BITS = lvl_off(LV + 1);
    localparam int SUM_OFF   = lvl_off(LV);

    // Elaboration-time guard on the structural parameters.
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("vec_dot_product_pipe: N must be a power of 2 and at least 2");
    end
    if (ACC_W < SW) begin : g_bad_acc
        $error("vec_dot_product_pipe: ACC_W must hold the full tree sum");
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic stall;
    logic adv;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // S0: registered input beat
    // ------------------------------------------------------------------
    logic           s0_valid;
    logic           s0_first;
    logic           s0_last;
    logic           s0_sgn;
    logic [N*W-1:0] s0_a;
    logic [N*W-1:0] s0_b;

    // Capture the accepted beat. This stage holds while the output is stalled.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge inputs and the stages shift in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_sgn   <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
        end else if (adv) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_first <= in_first;
                s0_last  <= in_last;
                s0_sgn   <= is_signed;
                s0_a     <= vec_a;
                s0_b     <= vec_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1 products and adder tree (flat vectors, level 0 = products)
    // ------------------------------------------------------------------
    logic [TREE_BITS-1:0] tree_d;
    logic [TREE_BITS-1:0] tree_q;
    logic [LV:0]          lvl_vld;
    logic [LV:0]          lvl_first;
    logic [LV:0]          lvl_last;
    logic [LV:0]          lvl_sgn;

    // Lane multipliers. Operands are extended to 2W bits per mode, so the
    // low 2W bits of the product are exact for both signed and unsigned.
    for (genvar i = 0; i < N; i++) begin : g_mul
        logic [PW-1:0] a_ext;
        logic [PW-1:0] b_ext;
        assign a_ext = {{W{s0_sgn & s0_a[i*W + W - 1]}}, s0_a[i*W +: W]};
        assign b_ext = {{W{s0_sgn & s0_b[i*W + W - 1]}}, s0_b[i*W +: W]};
        assign tree_d[i*PW +: PW] = a_ext * b_ext;
    end

    // Pairwise reduction. Level k adds two entries from level k-1 after
    // extending them by one bit, so no level ever truncates.
    for (genvar k = 1; k <= LV; k++) begin : g_lvl
        localparam int CW  = PW + k;
        localparam int IW  = CW - 1;
        localparam int CNT = N >> k;
        localparam int OFF = lvl_off(k);
        localparam int POF = lvl_off(k - 1);
        for (genvar j = 0; j < CNT; j++) begin : g_add
            logic [IW-1:0] lhs;
            logic [IW-1:0] rhs;
            assign lhs = tree_q[POF + (2*j)*IW     +: IW];
            assign rhs = tree_q[POF + (2*j + 1)*IW +: IW];
            assign tree_d[OFF + j*CW +: CW] =
                {lvl_sgn[k-1] & lhs[IW-1], lhs} + {lvl_sgn[k-1] & rhs[IW-1], rhs};
        end
    end

    // Register the products and every tree level. The beat tags travel
    // alongside the data.
    // NOTE: the data registers are reset along with the tags. This keeps the
    // datapath free of X after reset and adds no enable logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q    <= '0;
            lvl_vld   <= '0;
            lvl_first <= '0;
            lvl_last  <= '0;
            lvl_sgn   <= '0;
        end else if (adv) begin
            tree_q    <= tree_d;
            lvl_vld   <= {lvl_vld[LV-1:0],   s0_valid};
            lvl_first <= {lvl_first[LV-1:0], s0_first};
            lvl_last  <= {lvl_last[LV-1:0],  s0_last};
            lvl_sgn   <= {lvl_sgn[LV-1:0],   s0_sgn};
        end
    end

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [SW-1:0]    tree_sum;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             open_q;
    logic             acc_load;
    logic             carry;
    logic [ACC_W-1:0] add_res;
    logic             step_ovf;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;

    assign tree_sum = tree_q[SUM_OFF +: SW];
    assign sum_ext  = {{(ACC_W - SW){lvl_sgn[LV] & tree_sum[SW-1]}}, tree_sum};

    // Next accumulator value and overflow flag. A load starts a new result
    // with the flag clear. An add wraps modulo 2^ACC_W and keeps the flag set
    // once any step has overflowed.
    // NOTE: every output gets a default first, so no path through this
    // block can infer a latch.
    always_comb begin
        acc_load         = lvl_first[LV] || !open_q;
        {carry, add_res} = {1'b0, acc_q} + {1'b0, sum_ext};
        step_ovf         = carry;
        if (lvl_sgn[LV]) begin
            step_ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                       (add_res[ACC_W-1] != acc_q[ACC_W-1]);
        end
        acc_d = add_res;
        ovf_d = ovf_q | step_ovf;
        if (acc_load) begin
            acc_d = sum_ext;
            ovf_d = 1'b0;
        end
    end

    // Fold each tree sum into the running dot product. The open flag tracks
    // whether a dot product is currently in progress.
    // NOTE: the reset is asynchronous and active-low, so it must appear in
    // the sensitivity list next to the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            open_q <= 1'b0;
        end else if (adv && lvl_vld[LV]) begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            open_q <= !lvl_last[LV];
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Publish the result on a closing beat. A handshake edge either clears
    // out_valid or replaces the result with the next one that arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_dot      <= '0;
            out_overflow <= 1'b0;
        end else if (adv) begin
            out_valid <= lvl_vld[LV] && lvl_last[LV];
            if (lvl_vld[LV] && lvl_last[LV]) begin
                out_dot      <= acc_d;
                out_overflow <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_vec_dot_product_pipe.sv
// Scoreboard bench for vec_dot_product_pipe (N=8, W=8, ACC_W=27).
// The stimulus thread pushes the hand-computed result of each closing beat.
// The monitor pops and compares every result the DUT hands over. It also
// checks that a stalled result holds steady.
module tb_vec_dot_product_pipe;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int ACC_W = 27;

    typedef struct {
        logic [ACC_W-1:0] dot;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   vec_a;
    logic [N*W-1:0]   vec_b;
    logic             in_first;
    logic             in_last;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_dot;
    logic             out_overflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_pops   = 0;

    vec_dot_product_pipe #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vec_a        (vec_a),
        .vec_b        (vec_b),
        .in_first     (in_first),
        .in_last      (in_last),
        .is_signed    (is_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dot      (out_dot),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(i);
        return r;
    endfunction

    // Present one beat at the current negedge and hold it until accepted.
    // The task returns at the negedge after the accepting edge, with
    // in_valid still high so that beats can follow back-to-back.
    task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic first, input logic last, input logic sgn,
                        input logic [ACC_W-1:0] exp_dot, input logic exp_ovf);
        int guard;
        exp_t e;
        in_valid  = 1'b1;
        vec_a     = a;
        vec_b     = b;
        in_first  = first;
        in_last   = last;
        is_signed = sgn;
        guard     = 0;
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_accept_timeout", guard, 0);
        end else begin
            if (last) begin
                e.dot = exp_dot;
                e.ovf = exp_ovf;
                exp_q.push_back(e);
                n_pushed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pop on every handshake and verify that held results stay steady.
    initial begin : monitor
        logic             stalled_prev;
        logic [ACC_W-1:0] held_dot;
        logic             held_ovf;
        exp_t             e;
        stalled_prev = 1'b0;
        held_dot     = '0;
        held_ovf     = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_dot", out_dot, held_dot);
                    check("hold_ovf", out_overflow, held_ovf);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got dot=%0d, expected no result", out_dot);
                    end else begin
                        e = exp_q.pop_front();
                        n_pops++;
                        check("result_dot", out_dot, e.dot);
                        check("result_ovf", out_overflow, e.ovf);
                    end
                end
                stalled_prev = out_valid && !out_ready;
                held_dot     = out_dot;
                held_ovf     = out_overflow;
            end
        end
    end

    // Stimulus thread.
    initial begin : stimulus
        int lat;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        vec_a     = '0;
        vec_b     = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_dot", out_dot, 0);
        check("reset_out_overflow", out_overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single unsigned beat, 255*255 in every lane, plus latency.
        send(fill(8'd255), fill(8'd255), 1'b1, 1'b1, 1'b0, ACC_W'(520200), 1'b0);
        idle();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency_edges", lat, 5);
        repeat (4) @(negedge clk);

        // Single signed beat, -128 * 127 in every lane.
        send(fill(8'h80), fill(8'h7F), 1'b1, 1'b1, 1'b1, ACC_W'(-130048), 1'b0);
        idle();
        repeat (8) @(negedge clk);

        // Three back-to-back beats of ones: 8 + 8 + 8.
        send(fill(8'd1), fill(8'd1), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("b2b_in_ready_1", in_ready, 1);
        send(fill(8'd1), fill(8'd1), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("b2b_in_ready_2", in_ready, 1);
        send(fill(8'd1), fill(8'd1), 1'b0, 1'b1, 1'b0, ACC_W'(24), 1'b0);
        check("b2b_in_ready_3", in_ready, 1);
        idle();
        repeat (8) @(negedge clk);

        // Output stall: four pending results, consumer blocked for 10 cycles.
        out_ready = 1'b0;
        send(fill(8'd1),  fill(8'd2),  1'b1, 1'b1, 1'b0, ACC_W'(16), 1'b0);
        send(ramp(),      fill(8'd1),  1'b1, 1'b1, 1'b0, ACC_W'(28), 1'b0);
        send(fill(8'hFF), fill(8'd3),  1'b1, 1'b1, 1'b1, ACC_W'(-24), 1'b0);
        send(fill(8'd10), fill(8'd10), 1'b1, 1'b1, 1'b0, ACC_W'(800), 1'b0);
        idle();
        repeat (10) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_dot", out_dot, 16);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_drained", exp_q.size(), 0);

        // 259 unsigned all-255 beats wrap past 2^27, then a clean single beat.
        for (int i = 0; i < 259; i++) begin
            send(fill(8'd255), fill(8'd255), i == 0, i == 258, 1'b0, ACC_W'(514072), 1'b1);
        end
        send(fill(8'd1), fill(8'd1), 1'b1, 1'b1, 1'b0, ACC_W'(8), 1'b0);
        idle();
        repeat (10) @(negedge clk);

        // Reset in the middle of a three-beat product. The product is abandoned.
        send(fill(8'd1), fill(8'd1), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        send(fill(8'd1), fill(8'd1), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_dot", out_dot, 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("postreset_no_valid", out_valid, 0);
        send(fill(8'd1), fill(8'd1), 1'b1, 1'b1, 1'b0, ACC_W'(8), 1'b0);
        idle();

        // Drain any remaining results, with a bound on the wait.
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("results_received", n_pops, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
